// File: rtl/sme_feeder_if.sv
// Host-side byte stream and result handshake of the SME feeder.
interface sme_feeder_if;
  localparam int unsigned CHAR_W = 8;
  localparam int unsigned IDX_W  = 5;

  logic              in_valid;
  logic              in_ready;
  logic [CHAR_W-1:0] in_data;
  logic              in_kind;
  logic              in_last;
  logic              res_valid;
  logic              res_ready;
  logic              res_match;
  logic [IDX_W-1:0]  res_index;
  logic              res_timeout;
  logic              res_ovf;

  modport master (
    output in_valid, in_data, in_kind, in_last, res_ready,
    input  in_ready, res_valid, res_match, res_index, res_timeout, res_ovf
  );

  modport slave (
    input  in_valid, in_data, in_kind, in_last, res_ready,
    output in_ready, res_valid, res_match, res_index, res_timeout, res_ovf
  );
endinterface

// File: rtl/sme_feeder.sv
// Buffers host string/pattern frames, replays them to the SME as one
// contiguous burst and returns one captured result per pattern.
module sme_feeder #(
  parameter int unsigned STR_MAX = 32,
  parameter int unsigned PAT_MAX = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  sme_feeder_if.slave host,
  output logic [7:0]  chardata,
  output logic        isstring,
  output logic        ispattern,
  input  logic        sme_valid,
  input  logic        sme_match,
  input  logic [4:0]  sme_match_index
);
  localparam int unsigned CHAR_W  = 8;
  localparam int unsigned IDX_W   = 5;
  localparam int unsigned SLEN_W  = 6;
  localparam int unsigned PLEN_W  = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SADDR_W = $clog2(STR_MAX);
  localparam int unsigned PADDR_W = $clog2(PAT_MAX);
  localparam logic [SLEN_W-1:0] STR_CAP = SLEN_W'(STR_MAX);
  localparam logic [PLEN_W-1:0] PAT_CAP = PLEN_W'(PAT_MAX);
  localparam logic [CNT_W-1:0]  TO_LIM  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_STR, S_LOAD_PAT, S_SEND_STR, S_SEND_PAT, S_WAIT_RES, S_OUT_RES
  } state_t;

  state_t state, state_nx;

  logic [CHAR_W-1:0]  str_mem [STR_MAX];
  logic [CHAR_W-1:0]  pat_mem [PAT_MAX];

  logic [SLEN_W-1:0]  str_len, str_len_d;
  logic [PLEN_W-1:0]  pat_len, pat_len_d;
  logic               str_new, str_new_d;
  logic               ovf, ovf_d;
  logic [SLEN_W-1:0]  ptr, ptr_d;
  logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
  logic               in_ready_q, in_ready_d;
  logic [CHAR_W-1:0]  chardata_d;
  logic               isstring_d, ispattern_d;
  logic               res_valid_q, res_valid_d;
  logic               res_match_q, res_match_d;
  logic [IDX_W-1:0]   res_index_q, res_index_d;
  logic               res_timeout_q, res_timeout_d;
  logic               res_ovf_q, res_ovf_d;

  logic               accept, is_pat;
  logic [SLEN_W-1:0]  str_base, sidx, pidx;
  logic [PLEN_W-1:0]  pat_base;
  logic               str_we, pat_we;
  logic [SADDR_W-1:0] str_wa;
  logic [PADDR_W-1:0] pat_wa;

  assign accept  = host.in_valid & in_ready_q;
  assign cnt_inc = cnt + CNT_W'(1);

  assign host.in_ready    = in_ready_q;
  assign host.res_valid   = res_valid_q;
  assign host.res_match   = res_match_q;
  assign host.res_index   = res_index_q;
  assign host.res_timeout = res_timeout_q;
  assign host.res_ovf     = res_ovf_q;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (host.in_last) begin
            if (host.in_kind) state_nx = str_new ? S_SEND_STR : S_SEND_PAT;
            else              state_nx = S_IDLE;
          end else begin
            state_nx = host.in_kind ? S_LOAD_PAT : S_LOAD_STR;
          end
        end
      end
      S_LOAD_STR: if (accept && host.in_last) state_nx = S_IDLE;
      S_LOAD_PAT: if (accept && host.in_last) state_nx = str_new ? S_SEND_STR : S_SEND_PAT;
      S_SEND_STR: if (ptr >= str_len) state_nx = S_SEND_PAT;
      S_SEND_PAT: if (ptr >= SLEN_W'(pat_len)) state_nx = S_WAIT_RES;
      S_WAIT_RES: if (sme_valid || (cnt_inc == TO_LIM)) state_nx = S_OUT_RES;
      S_OUT_RES:  if (host.res_ready) state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Buffer writes, burst replay, result capture; next values of all registered outputs.
  always_comb begin
    str_len_d     = str_len;
    pat_len_d     = pat_len;
    str_new_d     = str_new;
    ovf_d         = ovf;
    ptr_d         = ptr;
    cnt_d         = '0;
    chardata_d    = '0;
    isstring_d    = 1'b0;
    ispattern_d   = 1'b0;
    res_valid_d   = res_valid_q;
    res_match_d   = res_match_q;
    res_index_d   = res_index_q;
    res_timeout_d = res_timeout_q;
    res_ovf_d     = res_ovf_q;
    str_we        = 1'b0;
    str_wa        = '0;
    pat_we        = 1'b0;
    pat_wa        = '0;
    is_pat        = (state == S_IDLE) ? host.in_kind : (state == S_LOAD_PAT);
    str_base      = (state == S_IDLE) ? '0 : str_len;
    pat_base      = (state == S_IDLE) ? '0 : pat_len;
    sidx          = (state == S_SEND_STR) ? ptr : '0;
    pidx          = (state == S_SEND_PAT) ? ptr : '0;

    if (accept) begin
      if (!is_pat) begin
        str_len_d = str_base;
        if (str_base < STR_CAP) begin
          str_we    = 1'b1;
          str_wa    = SADDR_W'(str_base);
          str_len_d = str_base + SLEN_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
        if (host.in_last) str_new_d = 1'b1;
      end else begin
        pat_len_d = pat_base;
        if (pat_base < PAT_CAP) begin
          pat_we    = 1'b1;
          pat_wa    = PADDR_W'(pat_base);
          pat_len_d = pat_base + PLEN_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    // Strobes follow the state they belong to; a one-beat pattern is forwarded straight from the bus.
    if (state_nx == S_SEND_STR) begin
      isstring_d = 1'b1;
      chardata_d = str_mem[SADDR_W'(sidx)];
      ptr_d      = sidx + SLEN_W'(1);
      str_new_d  = 1'b0;
    end else if (state_nx == S_SEND_PAT) begin
      ispattern_d = 1'b1;
      chardata_d  = (pat_we && (pat_wa == '0) && (pidx == '0)) ? host.in_data
                                                               : pat_mem[PADDR_W'(pidx)];
      ptr_d       = pidx + SLEN_W'(1);
    end

    if (state == S_WAIT_RES) begin
      cnt_d = cnt_inc;
      if (sme_valid) begin
        res_valid_d   = 1'b1;
        res_match_d   = sme_match;
        res_index_d   = sme_match ? sme_match_index : '0;
        res_timeout_d = 1'b0;
        res_ovf_d     = ovf;
        ovf_d         = 1'b0;
      end else if (cnt_inc == TO_LIM) begin
        res_valid_d   = 1'b1;
        res_match_d   = 1'b0;
        res_index_d   = '0;
        res_timeout_d = 1'b1;
        res_ovf_d     = ovf;
        ovf_d         = 1'b0;
      end
    end

    if ((state == S_OUT_RES) && host.res_ready) res_valid_d = 1'b0;

    in_ready_d = (state_nx == S_IDLE) || (state_nx == S_LOAD_STR) || (state_nx == S_LOAD_PAT);
  end

  // Control, datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_len       <= '0;
      pat_len       <= '0;
      str_new       <= 1'b0;
      ovf           <= 1'b0;
      ptr           <= '0;
      cnt           <= '0;
      in_ready_q    <= 1'b0;
      chardata      <= '0;
      isstring      <= 1'b0;
      ispattern     <= 1'b0;
      res_valid_q   <= 1'b0;
      res_match_q   <= 1'b0;
      res_index_q   <= '0;
      res_timeout_q <= 1'b0;
      res_ovf_q     <= 1'b0;
    end else begin
      str_len       <= str_len_d;
      pat_len       <= pat_len_d;
      str_new       <= str_new_d;
      ovf           <= ovf_d;
      ptr           <= ptr_d;
      cnt           <= cnt_d;
      in_ready_q    <= in_ready_d;
      chardata      <= chardata_d;
      isstring      <= isstring_d;
      ispattern     <= ispattern_d;
      res_valid_q   <= res_valid_d;
      res_match_q   <= res_match_d;
      res_index_q   <= res_index_d;
      res_timeout_q <= res_timeout_d;
      res_ovf_q     <= res_ovf_d;
    end
  end

  // Character storage; contents are only meaningful below the current lengths.
  always_ff @(posedge clk) begin
    if (str_we) str_mem[str_wa] <= host.in_data;
    if (pat_we) pat_mem[pat_wa] <= host.in_data;
  end
endmodule

// File: doc/sme_feeder.md
# sme_feeder

Front-end stage that sits directly upstream of the string-matching engine (SME). It accepts string and pattern frames from a host over a valid/ready byte stream and buffers them (string ≤32 chars, pattern ≤8 chars). It then replays them to the SME as the contiguous `chardata`/`isstring`/`ispattern` burst the engine expects, captures the engine's `valid`/`match`/`match_index`, and returns one result per pattern to the host over a second valid/ready handshake.

## Interface
- `STR_MAX`, 32, string buffer depth (chars)
- `PAT_MAX`, 8, pattern buffer depth (chars)
- `TIMEOUT`, 255, cycles to wait for SME `valid` after the burst ends
- `clk` in 1 — single clock; all logic rising-edge
- `reset` in 1 — asynchronous, active-low; asserting it immediately forces the reset state
- `in_valid` in 1 — host byte valid
- `in_ready` out 1 — feeder can accept a byte
- `in_data` in 8 — host character
- `in_kind` in 1 — 0 = string frame, 1 = pattern frame; sampled on first beat of a frame only
- `in_last` in 1 — last beat of the frame
- `chardata` out 8 — to SME
- `isstring` out 1 — to SME
- `ispattern` out 1 — to SME
- `sme_valid` in 1 — from SME
- `sme_match` in 1 — from SME
- `sme_match_index` in 5 — from SME
- `res_valid` out 1 — result available
- `res_ready` in 1 — host accepts result
- `res_match` out 1 — captured match
- `res_index` out 5 — captured match_index, 0 when no match
- `res_timeout` out 1 — SME gave no `valid` within TIMEOUT
- `res_ovf` out 1 — a char was dropped from the string or pattern feeding this result

## Operation
- States: IDLE, LOAD_STR, LOAD_PAT, SEND_STR, SEND_PAT, WAIT_RES, OUT_RES.
- IDLE: `in_ready`=1. The first accepted beat (`in_valid`&`in_ready`) selects the next state from `in_kind`:
  - kind 0: string write pointer cleared, byte stored at index 0, go to LOAD_STR.
  - kind 1: same for the pattern buffer, go to LOAD_PAT.
  - A one-beat frame (`in_last`=1 on the first beat) goes straight to the post-frame action below.
- LOAD_STR: store each byte and increment `str_len` (6-bit, saturates at STR_MAX).
  - Bytes beyond STR_MAX are discarded and set sticky `ovf`.
  - On `in_last`: set `str_new`=1, return to IDLE.
- LOAD_PAT: same rules, `pat_len` (4-bit, saturates at PAT_MAX).
  - On `in_last`: go to SEND_STR if `str_new`=1, else SEND_PAT.
  - A pattern with no string ever loaded (`str_len`=0) still goes to SEND_PAT; the SME result is passed through unchanged.
- SEND_STR: drive `isstring`=1 and `chardata`=str[k] for k=0..str_len-1, one per cycle. Clear `str_new`. Go directly to SEND_PAT with no gap cycle.
- SEND_PAT: drive `ispattern`=1 and `chardata`=pat[k] for k=0..pat_len-1. Then go to WAIT_RES with both strobes 0.
- WAIT_RES: a timeout counter (8-bit) runs.
  - On `sme_valid`=1: capture `sme_match` into `res_match`; capture `sme_match_index` into `res_index` if match, else 0; `res_timeout`=0.
  - If the counter reaches TIMEOUT first: `res_match`=0, `res_index`=0, `res_timeout`=1.
  - `res_ovf` is taken from sticky `ovf`, which then clears. Go to OUT_RES.
- OUT_RES: `res_valid`=1, outputs held stable until `res_ready`=1. On that handshake cycle go to IDLE.
- The string is retained across patterns: further pattern frames re-use it without resending, because the SME keeps its string when a pattern follows a result.
- `in_ready`=1 only in IDLE, LOAD_STR and LOAD_PAT.
- `in_kind` on non-first beats is ignored.
- A kind-0 frame arriving after patterns overwrites the string and sets `str_new`.

## Timing
- Reset values:
  - `in_ready`=0 during reset, 1 in the first cycle after release.
  - `chardata`=0, `isstring`=0, `ispattern`=0, `res_valid`=0, `res_match`=0, `res_index`=0, `res_timeout`=0, `res_ovf`=0.
  - Lengths, pointers, `str_new`, `ovf` and the timeout counter = 0; state = IDLE.
- SME-side outputs are registered. The first `isstring` cycle is the cycle after the clock edge that accepted the pattern's `in_last`.
- Burst length is exactly str_len+pat_len cycles (pat_len only when no new string). `isstring`/`ispattern` are never high together and never have a gap between them.
- `sme_valid` is sampled from the first WAIT_RES cycle. The result appears on `res_valid` the cycle after `sme_valid` is sampled.
- If `res_valid` and `res_ready` are both high in the same cycle, one transfer completes. `in_ready` rises in the next cycle.
- Reset asserted mid-burst: strobes drop asynchronously, buffers are logically emptied, and no result is produced.

## Test plan
- Reset release: all outputs 0; `in_ready`=1 one cycle later.
- String "ab cd" (5 beats) then pattern "cd" → `isstring` high for 5 cycles then `ispattern` for 2 cycles, contiguous. Model SME returns valid/match=1/index=3 → `res_valid`=1, `res_match`=1, `res_index`=3, `res_ovf`=0.
- Second pattern "zz" without a new string → only `ispattern` for 2 cycles. SME returns match=0 with index 7 → `res_index`=0.
- 40-char string then 10-char pattern → exactly 32 `isstring` and 8 `ispattern` cycles; `res_ovf`=1; the next result has `res_ovf`=0.
- SME never asserts valid → `res_timeout`=1 exactly 255 cycles after the burst ends, with `res_match`=0.
- Hold `res_ready`=0 for 10 cycles, then pulse it → outputs stable throughout, `in_ready` low until the cycle after the handshake. Separately, assert `reset` mid-SEND_STR → strobes 0 immediately and no `res_valid`.
